// File: rtl/io_bus_responder_if.sv
// io_bus_responder_if: LSU I/O request/response bus between a requester
// (master) and the io_bus_responder target (slave).
interface io_bus_responder_if;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_be;
  logic        o_ready;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_err;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_be,
    input  o_ready, o_rvalid, o_rdata, o_err
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_be,
    output o_ready, o_rvalid, o_rdata, o_err
  );
endinterface

// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped I/O target for the LSU request bus.
// Holds LEDR/LEDG/HEXL/HEXH/LCD output registers with byte-lane writes,
// returns a registered one-cycle response, synchronizes the switches and
// stalls LCD accesses for LCD_WAIT cycles to model a slow peripheral.
// Optional feature: define SW_DEBOUNCE_EN to add per-bit switch debouncing
// (DEBOUNCE_CYCLES stable cycles) after the synchronizer.
module io_bus_responder #(
  parameter int unsigned LCD_WAIT        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  io_bus_responder_if.slave bus,
  input  logic [31:0]       i_io_sw,
  output logic [31:0]       o_io_ledr,
  output logic [31:0]       o_io_ledg,
  output logic [31:0]       o_io_hexl,
  output logic [31:0]       o_io_hexh,
  output logic [31:0]       o_io_lcd
);

  typedef enum logic {IDLE, LCD_WAIT_S} state_t;

  typedef enum logic [2:0] {
    TGT_LEDR, TGT_LEDG, TGT_HEXL, TGT_HEXH, TGT_LCD, TGT_SW, TGT_NONE
  } target_t;

  state_t      state_q;
  logic [3:0]  waitCnt_q;
  logic        lcdWe_q;
  logic [31:0] lcdWdata_q;
  logic [3:0]  lcdBe_q;
  logic [31:0] ledr_q, ledg_q, hexl_q, hexh_q, lcd_q;
  logic        rvalid_q, err_q;
  logic [31:0] rdata_q;
  logic [31:0] swSync1_q, swSync2_q;
  logic [31:0] swValue;
  target_t     target;
  logic [31:0] readData;
  logic [31:0] wrNext_d;
  logic [31:0] lcdNext_d;
  logic        accept;
  logic        unusedAddrBits;

  // Only the window and page bits take part in decode; the offset is don't-care.
  assign unusedAddrBits = ^bus.i_addr[11:0];

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = oldVal;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) res[8*n +: 8] = newVal[8*n +: 8];
    end
    return res;
  endfunction

  assign accept       = bus.i_req && (state_q == IDLE);
  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_err    = err_q;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_hexl    = hexl_q;
  assign o_io_hexh    = hexh_q;
  assign o_io_lcd     = lcd_q;

  // Address decode of the request currently on the bus.
  always_comb begin
    target = TGT_NONE;
    if (bus.i_addr[31:16] == 16'h1000) begin
      case (bus.i_addr[15:12])
        4'h0:    target = TGT_LEDR;
        4'h1:    target = TGT_LEDG;
        4'h2:    target = TGT_HEXL;
        4'h3:    target = TGT_HEXH;
        4'h4:    target = TGT_LCD;
        default: target = TGT_NONE;
      endcase
    end else if (bus.i_addr[31:16] == 16'h1001) begin
      target = TGT_SW;
    end
  end

  // Read mux for the decoded target, and the lane-merged write values.
  always_comb begin
    readData = 32'h0;
    case (target)
      TGT_LEDR: readData = ledr_q;
      TGT_LEDG: readData = ledg_q;
      TGT_HEXL: readData = hexl_q;
      TGT_HEXH: readData = hexh_q;
      TGT_LCD:  readData = lcd_q;
      TGT_SW:   readData = swValue;
      default:  readData = 32'h0;
    endcase
    wrNext_d  = mergeLanes(readData, bus.i_wdata, bus.i_be);
    lcdNext_d = mergeLanes(lcd_q, lcdWdata_q, lcdBe_q);
  end

  // Request FSM: completes fast targets at the accept edge, stalls LCD accesses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'h0;
      lcdWe_q    <= 1'b0;
      lcdWdata_q <= 32'h0;
      lcdBe_q    <= 4'h0;
      ledr_q     <= 32'h0;
      ledg_q     <= 32'h0;
      hexl_q     <= 32'h0;
      hexh_q     <= 32'h0;
      lcd_q      <= 32'h0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (target == TGT_LCD) begin
              lcdWe_q    <= bus.i_we;
              lcdWdata_q <= bus.i_wdata;
              lcdBe_q    <= bus.i_be;
              waitCnt_q  <= 4'(LCD_WAIT - 1);
              state_q    <= LCD_WAIT_S;
            end else if (target == TGT_NONE || (target == TGT_SW && bus.i_we)) begin
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= 32'h0;
            end else begin
              rvalid_q <= 1'b1;
              err_q    <= 1'b0;
              rdata_q  <= bus.i_we ? 32'h0 : readData;
              if (bus.i_we) begin
                case (target)
                  TGT_LEDR: ledr_q <= wrNext_d;
                  TGT_LEDG: ledg_q <= wrNext_d;
                  TGT_HEXL: hexl_q <= wrNext_d;
                  TGT_HEXH: hexh_q <= wrNext_d;
                  default:  ;
                endcase
              end
            end
          end
        end
        LCD_WAIT_S: begin
          if (waitCnt_q == 4'h0) begin
            rvalid_q <= 1'b1;
            err_q    <= 1'b0;
            if (lcdWe_q) begin
              lcd_q   <= lcdNext_d;
              rdata_q <= 32'h0;
            end else begin
              rdata_q <= lcd_q;
            end
            state_q <= IDLE;
          end else begin
            waitCnt_q <= waitCnt_q - 4'h1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      swSync1_q <= 32'h0;
      swSync2_q <= 32'h0;
    end else begin
      swSync1_q <= i_io_sw;
      swSync2_q <= swSync1_q;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] dbCnt_q [32];
  logic [31:0]     swStable_q;

  // Per-bit debounce: accept a new level only after it persists, restart on bounce.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      swStable_q <= 32'h0;
      for (int i = 0; i < 32; i++) dbCnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (swSync2_q[i] != swStable_q[i]) begin
          if (dbCnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            swStable_q[i] <= swSync2_q[i];
            dbCnt_q[i]    <= '0;
          end else begin
            dbCnt_q[i] <= dbCnt_q[i] + DB_W'(1);
          end
        end else begin
          dbCnt_q[i] <= '0;
        end
      end
    end
  end

  assign swValue = swStable_q;
`else
  logic unusedDebounceCfg;

  // Without debouncing the debounce length has no effect.
  assign unusedDebounceCfg = (DEBOUNCE_CYCLES != 0);
  assign swValue           = swSync2_q;
`endif

endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: directed and randomized checks of io_bus_responder
// against a transaction-level model of the register map and timing.
`timescale 1ns/1ps
module tb_io_bus_responder;
  localparam int LCD_WAIT        = 4;
  localparam int DEBOUNCE_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sw;
  logic [31:0] ledr, ledg, hexl, hexh, lcd;

  io_bus_responder_if bus();

  io_bus_responder #(
    .LCD_WAIT(LCD_WAIT),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus),
    .i_io_sw(sw),
    .o_io_ledr(ledr),
    .o_io_ledg(ledg),
    .o_io_hexl(hexl),
    .o_io_hexh(hexh),
    .o_io_lcd(lcd)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state: register file indexed LEDR..LCD, pending slow access, response.
  logic [31:0] mRegs [5];
  logic        mPending;
  int          mDoneEdge;
  logic        mLcdWe;
  logic [31:0] mLcdWdata;
  logic [3:0]  mLcdBe;
  int          mEdge;
  logic        mRvalid, mErr;
  logic [31:0] mRdata;
  logic [31:0] mSwP1, mSwP2, mSwDeb;
  int          mStreak [32];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  // 0..4 = LEDR..LCD, 5 = SW, 6 = unmapped
  function automatic int decode(input logic [31:0] a);
    logic [15:0] hi;
    logic [3:0]  pg;
    hi = a[31:16];
    pg = a[15:12];
    if (hi == 16'h1000 && pg < 4'd5) return int'(pg);
    if (hi == 16'h1001) return 5;
    return 6;
  endfunction

  task automatic resetModel();
    for (int k = 0; k < 5; k++) mRegs[k] = 32'h0;
    mPending = 1'b0; mDoneEdge = 0; mLcdWe = 1'b0; mLcdWdata = 32'h0; mLcdBe = 4'h0;
    mEdge = 0; mRvalid = 1'b0; mErr = 1'b0; mRdata = 32'h0;
    mSwP1 = 32'h0; mSwP2 = 32'h0; mSwDeb = 32'h0;
    for (int b = 0; b < 32; b++) mStreak[b] = 0;
  endtask

  task automatic modelStep();
    logic        rdy;
    int          tgt;
    logic [31:0] swNow;
    rdy = !mPending;
`ifdef SW_DEBOUNCE_EN
    swNow = mSwDeb;
`else
    swNow = mSwP2;
`endif
    mRvalid = 1'b0;
    if (mPending && mEdge == mDoneEdge) begin
      mPending = 1'b0;
      mRvalid  = 1'b1;
      mErr     = 1'b0;
      if (mLcdWe) begin
        mRegs[4] = merge(mRegs[4], mLcdWdata, mLcdBe);
        mRdata   = 32'h0;
      end else begin
        mRdata = mRegs[4];
      end
    end else if (rdy && bus.i_req) begin
      tgt = decode(bus.i_addr);
      if (tgt == 4) begin
        mPending  = 1'b1;
        mLcdWe    = bus.i_we;
        mLcdWdata = bus.i_wdata;
        mLcdBe    = bus.i_be;
        mDoneEdge = mEdge + LCD_WAIT;
      end else begin
        mRvalid = 1'b1;
        if (tgt == 6 || (tgt == 5 && bus.i_we)) begin
          mErr = 1'b1; mRdata = 32'h0;
        end else if (bus.i_we) begin
          mErr = 1'b0; mRdata = 32'h0;
          mRegs[tgt] = merge(mRegs[tgt], bus.i_wdata, bus.i_be);
        end else begin
          mErr = 1'b0;
          mRdata = (tgt == 5) ? swNow : mRegs[tgt];
        end
      end
    end
`ifdef SW_DEBOUNCE_EN
    for (int b = 0; b < 32; b++) begin
      if (mSwP2[b] != mSwDeb[b]) begin
        mStreak[b]++;
        if (mStreak[b] == DEBOUNCE_CYCLES) begin
          mSwDeb[b]  = mSwP2[b];
          mStreak[b] = 0;
        end
      end else begin
        mStreak[b] = 0;
      end
    end
`endif
    mSwP2 = mSwP1;
    mSwP1 = sw;
    mEdge++;
  endtask

  // Advance the model on every active clock edge outside reset.
  always @(posedge clk) begin
    if (!rst) modelStep();
  end

  // Compare all DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("ready",  {31'h0, bus.o_ready},  {31'h0, !mPending});
      checkOutput("rvalid", {31'h0, bus.o_rvalid}, {31'h0, mRvalid});
      checkOutput("rdata",  bus.o_rdata, mRdata);
      checkOutput("err",    {31'h0, bus.o_err}, {31'h0, mErr});
      checkOutput("ledr", ledr, mRegs[0]);
      checkOutput("ledg", ledg, mRegs[1]);
      checkOutput("hexl", hexl, mRegs[2]);
      checkOutput("hexh", hexh, mRegs[3]);
      checkOutput("lcd",  lcd,  mRegs[4]);
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance, req still high.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int n;
    bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wdata; bus.i_be = be;
    n = 0;
    while (!bus.o_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL acceptTimeout: ready stayed 0, required 1 within 40 cycles");
    end
    @(negedge clk);
  endtask

  task automatic awaitResponse(output logic [31:0] rd, output logic er,
                               output int lat, output int lowCycles);
    lat = 1;
    lowCycles = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.o_rvalid) break;
      if (!bus.o_ready) lowCycles++;
      @(negedge clk);
      lat++;
    end
    if (!bus.o_rvalid) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL responseTimeout: rvalid stayed 0, required 1 within 40 cycles");
    end
    rd = bus.o_rdata;
    er = bus.o_err;
  endtask

  task automatic midCycleReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstLedr",   ledr, 32'h0);
    checkOutput("rstLcd",    lcd,  32'h0);
    checkOutput("rstRvalid", {31'h0, bus.o_rvalid}, 32'h0);
    checkOutput("rstRdata",  bus.o_rdata, 32'h0);
    checkOutput("rstReady",  {31'h0, bus.o_ready}, 32'h1);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, low, seen, gap, pick;
  logic [31:0] addr;

  initial begin
    sw = 32'h0;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0; bus.i_be = 4'h0;
    resetModel();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("initReady", {31'h0, bus.o_ready}, 32'h1);
    checkOutput("initLedr", ledr, 32'h0);

    // Byte-lane writes and readback
    applyStimulus(1'b1, 32'h1000_0000, 32'hAABBCCDD, 4'hF);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("wr1Latency", 32'(lat), 32'd1);
    checkOutput("wr1Err", {31'h0, er}, 32'h0);
    applyStimulus(1'b1, 32'h1000_0ABC, 32'h11223344, 4'b0100);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("wr2Latency", 32'(lat), 32'd1);
    applyStimulus(1'b0, 32'h1000_0000, 32'h0, 4'h0);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("ledrReadback", rd, 32'hAA22CCDD);

    // Empty byte enable acknowledges without writing
    applyStimulus(1'b1, 32'h1000_1000, 32'hFFFFFFFF, 4'h0);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("beZeroLedg", ledg, 32'h0);

    // LCD wait states
    applyStimulus(1'b1, 32'h1000_4000, 32'h12345678, 4'hF);
    bus.i_req = 1'b0;
    checkOutput("lcdBeforeDone", lcd, 32'h0);
    awaitResponse(rd, er, lat, low);
    checkOutput("lcdWrLatency", 32'(lat), 32'(LCD_WAIT + 1));
    checkOutput("lcdReadyLow", 32'(low), 32'(LCD_WAIT));
    checkOutput("lcdAfterDone", lcd, 32'h12345678);
    applyStimulus(1'b0, 32'h1000_4010, 32'h0, 4'hF);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("lcdRead", rd, 32'h12345678);

    // Error responses
    applyStimulus(1'b1, 32'h1001_0000, 32'hDEADBEEF, 4'hF);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("swWriteErr", {31'h0, er}, 32'h1);
    checkOutput("swWriteRdata", rd, 32'h0);
    applyStimulus(1'b0, 32'h1000_7000, 32'h0, 4'hF);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("unmappedErr", {31'h0, er}, 32'h1);
    checkOutput("unmappedLatency", 32'(lat), 32'd1);
    checkOutput("ledrUntouched", ledr, 32'hAA22CCDD);

    // Back-to-back write then read of HEXL
    applyStimulus(1'b1, 32'h1000_2000, 32'h00000079, 4'hF);
    checkOutput("b2bWriteAck", {31'h0, bus.o_rvalid}, 32'h1);
    applyStimulus(1'b0, 32'h1000_2000, 32'h0, 4'h0);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("b2bReadLatency", 32'(lat), 32'd1);
    checkOutput("b2bReadData", rd, 32'h00000079);
    checkOutput("hexDigit0", {25'h0, hexl[6:0]}, 32'h79);

    // Switch path
`ifndef SW_DEBOUNCE_EN
    sw = 32'h5;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 32'h1001_0000, 32'h0, 4'h0);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("swSynced", rd, 32'h5);
`else
    sw = 32'hF0;
    repeat (5) @(negedge clk);
    sw = 32'h0;
    repeat (30) @(negedge clk);
    applyStimulus(1'b0, 32'h1001_0000, 32'h0, 4'h0);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("swGlitchHidden", rd, 32'h0);
    sw = 32'hA;
    repeat (DEBOUNCE_CYCLES + 2) @(negedge clk);
    applyStimulus(1'b0, 32'h1001_0000, 32'h0, 4'h0);
    bus.i_req = 1'b0;
    awaitResponse(rd, er, lat, low);
    checkOutput("swDebounced", rd, 32'hA);
`endif

    // Reset in the middle of an LCD wait aborts the access
    applyStimulus(1'b1, 32'h1000_4000, 32'hCAFEF00D, 4'hF);
    bus.i_req = 1'b0;
    midCycleReset();
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.o_rvalid) seen++;
    end
    checkOutput("abortNoRvalid", 32'(seen), 32'd0);
    checkOutput("abortLcd", lcd, 32'h0);

    // Randomized traffic, with switch changes and back-to-back requests
    for (int it = 0; it < 500; it++) begin
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        bus.i_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
      if ($urandom_range(0, 9) == 0) sw = $urandom;
      pick = $urandom_range(0, 7);
      if (pick < 5)       addr = 32'h1000_0000 | (32'(pick) << 12) | 32'($urandom_range(0, 4095));
      else if (pick == 5) addr = 32'h1001_0000 | 32'($urandom_range(0, 65535));
      else if (pick == 6) addr = 32'h1000_5000 | (32'($urandom_range(0, 10)) << 12);
      else                addr = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
    end
    bus.i_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
